hex_display_checker: RTL
========================

Name: hex_display_checker

Overview:
Receive-side counterpart of the counter's 7-segment display path. Samples the five HEX glyph buses on each sync tick, decodes the glyphs back to a number, and checks each new value against the previous one for the commanded direction and hold state. Reports decoded value, glyph errors, step errors and a saturating error count, as an on-board self-check of the counter/display encoder.

Parameters:
Modulus, 32, counter wrap modulus; a decoded value >= Modulus is a step error.
Radix, 10, digit radix, 10 or 16; digit i (HEX index i) weighs Radix**i.
SettleCycles, 2, clocks waited after a detected tick before glyphs are captured (range 0..15).

Ports:
i_clock_50mhz  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_HEXs  in  [6:0] x [4:0] (unpacked)  glyphs, active-low, bit order g f e d c b a (bit0 = a)
i_sync_clock  in  1  counter tick, asynchronous level
i_direction  in  1  1 = counting up, 0 = down
i_hold  in  1  1 = counter paused, expected delta 0
i_resync  in  1  one-clock pulse; next capture becomes baseline (counter set/reset)
o_value  out  20  last good decoded value
o_valid  out  1  one-clock pulse, new value checked
o_glyph_error  out  1  one-clock pulse
o_step_error  out  1  one-clock pulse
o_error_count  out  8  saturating error counter
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM IDLE, baseline invalid, sync flops 0.
- i_sync_clock passes 2 flops plus edge register; rising edge recognised 3 clocks after first sampled high.
- FSM: IDLE -(edge)-> SETTLE (SettleCycles clocks; 0 = skip) -> CAPTURE (register all 5 glyphs) -> COMPARE (decode, check, drive pulses) -> IDLE.
- Latency: pulses asserted exactly SettleCycles+5 clocks after first clock edge sampling i_sync_clock high; pulses last 1 clock.
- Decode table (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex). Any other pattern, or A-F when Radix=10: glyph error.
- Glyph error: o_glyph_error=1, o_valid=0, o_value unchanged, baseline invalidated.
- Good decode with baseline invalid: o_valid=1, o_value updated, no step check, baseline valid.
- Good decode with baseline valid: expected = prev if i_hold; prev+1 wrapping Modulus-1 -> 0 if up; prev-1 wrapping 0 -> Modulus-1 if down. Direction/hold sampled in CAPTURE. Mismatch or value >= Modulus: o_step_error=1 plus o_valid=1; o_value and baseline always take the new value.
- o_error_count += 1 per glyph or step error; holds at 255; cleared only by reset.
- Edge while busy: dropped; sets missed flag; next capture treated as baseline (no step check); flag cleared then.
- i_resync any cycle: baseline invalid; if it coincides with COMPARE, that capture is treated as baseline.
- Reset in any state: returns to IDLE next clock, no pulses.

Optional Feature:
HEX_CHECKER_BLANK_EN: defined -> glyph 7F (all off) decodes as digit 0 only if every higher-index digit is also 7F (leading-zero blanking); elsewhere glyph error. Undefined -> 7F is always a glyph error.

Test Plan:
- Reset, then tick with HEX0=79 (1), others 40 -> o_valid, o_value=1, no errors, o_error_count=0.
- Up, ticks showing 30 then 31 then 0 -> values 30,31,0, no step error (wrap at Modulus 32).
- Down, baseline 0, next tick shows 31 -> no error; next shows 29 -> o_step_error, o_error_count=1.
- i_hold=1, baseline 12, tick shows 13 -> o_step_error; shows 12 -> clean.
- HEX1=08 with Radix=10 -> o_glyph_error, o_value unchanged; next tick with any value -> clean baseline.
- i_resync pulse, tick shows 9 after 5 -> no step error; 300 ticks of errors -> o_error_count=255.

Source files
------------

// File: rtl/hex_display_checker.sv
// hex_display_checker: receive-side self-check for the counter's 7-segment path.
// Samples the five active-low HEX glyph buses after each sync tick, decodes
// them back to a number, and checks each new value against the previous one
// for the commanded direction and hold state.
// Optional build macro: HEX_CHECKER_BLANK_EN enables leading-zero blanking
// (glyph 7F decodes as 0 when every higher-index glyph is also blank).
// Handshake: o_valid / o_glyph_error / o_step_error are single-clock pulses
// with no ready; they fire SettleCycles+5 clocks after the first clock edge
// that samples i_sync_clock high, and the consumer must take them that cycle.
module hex_display_checker #(
   parameter int Modulus      = 32,
   parameter int Radix        = 10,
   parameter int SettleCycles = 2
) (
   input  logic        i_clock_50mhz,
   input  logic        i_reset,
   input  logic [6:0]  i_HEXs [4:0],
   input  logic        i_sync_clock,
   input  logic        i_direction,
   input  logic        i_hold,
   input  logic        i_resync,
   output logic [19:0] o_value,
   output logic        o_valid,
   output logic        o_glyph_error,
   output logic        o_step_error,
   output logic [7:0]  o_error_count,
   output logic        o_busy,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_CAPTURE = 2'd2,
      S_COMPARE = 2'd3
   } state_t;

   state_t      state_q;
   logic [3:0]  settle_cnt_q;
   logic        sync1_q, sync2_q, sync3_q;
   logic [6:0]  glyph_q [4:0];
   logic        dir_q, hold_q;
   logic        base_valid_q;
   logic        missed_q;
   logic [19:0] value_q;
   logic        valid_q, glyph_err_q, step_err_q;
   logic [7:0]  err_cnt_q;

   logic        tick_edge;
   logic [19:0] dec_value;
   logic        glyph_bad;
   logic [19:0] expected;
   logic        step_bad;
   logic [3:0]  digit;
   logic        digit_ok;
`ifdef HEX_CHECKER_BLANK_EN
   logic        blank_run;
`endif

   // Two-flop synchroniser for the asynchronous tick plus an edge register.
   always_ff @(posedge i_clock_50mhz) begin
      if (i_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= i_sync_clock;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign tick_edge = sync2_q & ~sync3_q;

   // Decode the captured glyphs, most significant digit first.
   always_comb begin
      dec_value = '0;
      glyph_bad = 1'b0;
      digit     = '0;
      digit_ok  = 1'b0;
`ifdef HEX_CHECKER_BLANK_EN
      blank_run = 1'b1;
`endif
      for (int i = 4; i >= 0; i--) begin
         digit_ok = 1'b1;
         digit    = 4'd0;
         case (glyph_q[i])
            7'h40: digit = 4'h0;
            7'h79: digit = 4'h1;
            7'h24: digit = 4'h2;
            7'h30: digit = 4'h3;
            7'h19: digit = 4'h4;
            7'h12: digit = 4'h5;
            7'h02: digit = 4'h6;
            7'h78: digit = 4'h7;
            7'h00: digit = 4'h8;
            7'h10: digit = 4'h9;
            7'h08: digit = 4'hA;
            7'h03: digit = 4'hB;
            7'h46: digit = 4'hC;
            7'h21: digit = 4'hD;
            7'h06: digit = 4'hE;
            7'h0E: digit = 4'hF;
            default: digit_ok = 1'b0;
         endcase
         if (int'(digit) >= Radix) digit_ok = 1'b0;
`ifdef HEX_CHECKER_BLANK_EN
         // A blank glyph is a leading zero only while everything above it is blank.
         if (glyph_q[i] == 7'h7F && blank_run) begin
            digit_ok = 1'b1;
            digit    = 4'd0;
         end
         blank_run = blank_run && (glyph_q[i] == 7'h7F);
`endif
         if (!digit_ok) glyph_bad = 1'b1;
         dec_value = dec_value * 20'(Radix) + 20'(digit);
      end
   end

   // Expected successor of the previous value, and the resulting step verdict.
   always_comb begin
      expected = value_q;
      if (!hold_q) begin
         if (dir_q) expected = (value_q == 20'(Modulus - 1)) ? 20'd0 : value_q + 20'd1;
         else       expected = (value_q == 20'd0) ? 20'(Modulus - 1) : value_q - 20'd1;
      end
      step_bad = (dec_value >= 20'(Modulus)) || (dec_value != expected);
   end

   // Capture/compare FSM with registered result pulses and error counter.
   always_ff @(posedge i_clock_50mhz) begin
      if (i_reset) begin
         state_q      <= S_IDLE;
         settle_cnt_q <= '0;
         for (int i = 0; i < 5; i++) glyph_q[i] <= '0;
         dir_q        <= 1'b0;
         hold_q       <= 1'b0;
         base_valid_q <= 1'b0;
         missed_q     <= 1'b0;
         value_q      <= '0;
         valid_q      <= 1'b0;
         glyph_err_q  <= 1'b0;
         step_err_q   <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         valid_q     <= 1'b0;
         glyph_err_q <= 1'b0;
         step_err_q  <= 1'b0;
         if (i_resync) base_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (tick_edge) begin
                  if (SettleCycles == 0) begin
                     state_q <= S_CAPTURE;
                  end else begin
                     state_q      <= S_SETTLE;
                     settle_cnt_q <= 4'(SettleCycles - 1);
                  end
               end
            end
            S_SETTLE: begin
               if (tick_edge) missed_q <= 1'b1;
               if (settle_cnt_q == 4'd0) state_q <= S_CAPTURE;
               else                      settle_cnt_q <= settle_cnt_q - 4'd1;
            end
            S_CAPTURE: begin
               if (tick_edge) missed_q <= 1'b1;
               for (int i = 0; i < 5; i++) glyph_q[i] <= i_HEXs[i];
               dir_q   <= i_direction;
               hold_q  <= i_hold;
               state_q <= S_COMPARE;
            end
            S_COMPARE: begin
               // This capture consumes any earlier dropped tick; a tick arriving now is dropped in turn.
               missed_q <= tick_edge;
               if (glyph_bad) begin
                  glyph_err_q  <= 1'b1;
                  base_valid_q <= 1'b0;
                  if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
               end else begin
                  valid_q      <= 1'b1;
                  value_q      <= dec_value;
                  base_valid_q <= 1'b1;
                  if (base_valid_q && !missed_q && !i_resync && step_bad) begin
                     step_err_q <= 1'b1;
                     if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                  end
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_value       = value_q;
   assign o_valid       = valid_q;
   assign o_glyph_error = glyph_err_q;
   assign o_step_error  = step_err_q;
   assign o_error_count = err_cnt_q;
   assign o_busy        = (state_q != S_IDLE);
   assign o_dbg_state   = state_q;

endmodule
